// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame FSM encoding, frame bit levels and
// scan-code prefixes also used by the key-matrix converter.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// First-word fall-through byte FIFO with rd handshake and overrun pulse.
// Built only when PS2_RX_FIFO_EN is defined.
module ps2_byte_fifo
    import ps2_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       rd,
    output logic [7:0] data,
    output logic       valid,
    output logic       overrun
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [7:0]    hold;
    logic          pop;
    logic          full;
    logic          wr;

    assign valid = (count != '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = rd && valid;
    // A pop frees the head slot in the same cycle, so a full push still lands.
    assign wr    = push && (!full || pop);
    assign data  = valid ? mem[rptr] : hold;

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            hold    <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr)  wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            if (pop) hold <= mem[rptr];
            count   <= count + (AW+1)'(wr) - (AW+1)'(pop);
            overrun <= push && full && !pop;
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host deframer: sync, tick, clock filter, frame FSM, buffer.
// Define PS2_RX_FIFO_EN for a 2**FIFO_AW byte FIFO instead of one register.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV       = 250,
    parameter int FILT_LEN      = 4,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int FIFO_AW       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       rd,
    output logic [7:0] data,
    output logic       valid,
    output logic       err_parity,
    output logic       err_frame,
    output logic       overrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RUN_W = $clog2(FILT_LEN + 1);
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

    logic             clk_s1, clk_s2, dat_s1, dat_s2;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             filt_clk;
    logic [RUN_W-1:0] run_cnt;
    logic             fall;

    ps2_state_t state, state_n;
    logic [7:0]      shreg, shreg_n;
    logic [2:0]      bitcnt, bitcnt_n;
    logic            par, par_n;
    logic [TO_W-1:0] to_cnt, to_n;
    logic            push, perr_n, ferr_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) div_cnt <= '0;
        else      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end

    // Filtered level flips only after FILT_LEN consecutive differing ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_clk <= 1'b1;
            run_cnt  <= '0;
        end else if (tick) begin
            if (clk_s2 != filt_clk) begin
                if (run_cnt == RUN_W'(FILT_LEN - 1)) begin
                    filt_clk <= ~filt_clk;
                    run_cnt  <= '0;
                end else begin
                    run_cnt <= run_cnt + RUN_W'(1);
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

    assign fall = tick && filt_clk && !clk_s2 &&
                  (run_cnt == RUN_W'(FILT_LEN - 1));

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bitcnt_n = bitcnt;
        par_n    = par;
        to_n     = to_cnt;
        push     = 1'b0;
        perr_n   = 1'b0;
        ferr_n   = 1'b0;

        if (state == IDLE || fall) to_n = '0;
        else if (tick)             to_n = to_cnt + TO_W'(1);

        if (state != IDLE && tick && !fall &&
            to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
            state_n = IDLE;
            ferr_n  = 1'b1;
            shreg_n = '0;
            to_n    = '0;
        end else if (fall) begin
            unique case (state)
                IDLE: begin
                    if (dat_s2 == START_BIT) begin
                        state_n  = DATA;
                        bitcnt_n = '0;
                        shreg_n  = '0;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end
                DATA: begin
                    shreg_n  = {dat_s2, shreg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_n   = dat_s2;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (dat_s2 != STOP_BIT)              ferr_n = 1'b1;
                    else if (!odd_parity_ok(shreg, par)) perr_n = 1'b1;
                    else                                 push   = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            par        <= 1'b0;
            to_cnt     <= '0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bitcnt     <= bitcnt_n;
            par        <= par_n;
            to_cnt     <= to_n;
            err_parity <= perr_n;
            err_frame  <= ferr_n;
        end
    end

`ifdef PS2_RX_FIFO_EN
    ps2_byte_fifo #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(shreg),
        .rd       (rd),
        .data     (data),
        .valid    (valid),
        .overrun  (overrun)
    );
`else
    // Single holding register; a simultaneous rd makes room for the push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (push) begin
                if (!valid || rd) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rd && valid) begin
                valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx with reduced timing parameters.
module tb_ps2_frame_rx;

    localparam int HALF = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       err_parity;
    logic       err_frame;
    logic       overrun;

    int checks = 0;
    int failures = 0;
    int n_perr = 0;
    int n_ferr = 0;
    int n_ovr = 0;

    always #5 clk = ~clk;

    ps2_frame_rx #(
        .CLK_DIV      (4),
        .FILT_LEN     (2),
        .TIMEOUT_TICKS(50),
        .FIFO_AW      (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .rd        (rd),
        .data      (data),
        .valid     (valid),
        .err_parity(err_parity),
        .err_frame (err_frame),
        .overrun   (overrun)
    );

    always @(negedge clk) begin
        if (err_parity) n_perr++;
        if (err_frame)  n_ferr++;
        if (overrun)    n_ovr++;
    end

    task automatic send_bit(input logic b);
        ps2_dat = b;
        #(HALF);
        ps2_clk = 1'b0;
        #(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b ^ bad_par);
        send_bit(stop);
        ps2_dat = 1'b1;
        #(HALF * 2);
    endtask

    task automatic pop();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if (data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00", data);
        end
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", valid);
        end
        checks++;
        if ({err_parity, err_frame, overrun} !== 3'b000) begin
            failures++;
            $display("FAIL reset_pulses got=%b exp=000",
                     {err_parity, err_frame, overrun});
        end
        @(negedge clk);
        rst = 1'b1;
        #100;
    endtask

    task automatic test_single();
        int pe, fe;
        pe = n_perr;
        fe = n_ferr;
        send_frame(8'h1C, 1'b0, 1'b1);
        checks++;
        if (valid !== 1'b1) begin
            failures++;
            $display("FAIL single_valid got=%b exp=1", valid);
        end
        checks++;
        if (data !== 8'h1C) begin
            failures++;
            $display("FAIL single_data got=%h exp=1c", data);
        end
        checks++;
        if (n_perr != pe || n_ferr != fe) begin
            failures++;
            $display("FAIL single_errs got=%0d/%0d exp=0/0",
                     n_perr - pe, n_ferr - fe);
        end
        pop();
        checks++;
        if (valid !== 1'b0 || data !== 8'h1C) begin
            failures++;
            $display("FAIL single_pop got=%b/%h exp=0/1c", valid, data);
        end
    endtask

    task automatic test_two_frames();
        int ov;
        ov = n_ovr;
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        checks++;
        if (valid !== 1'b1 || data !== 8'hF0) begin
            failures++;
            $display("FAIL two_head got=%b/%h exp=1/f0", valid, data);
        end
`ifdef PS2_RX_FIFO_EN
        checks++;
        if (n_ovr != ov) begin
            failures++;
            $display("FAIL two_ovr got=%0d exp=0", n_ovr - ov);
        end
        pop();
        checks++;
        if (valid !== 1'b1 || data !== 8'h1C) begin
            failures++;
            $display("FAIL two_second got=%b/%h exp=1/1c", valid, data);
        end
        pop();
`else
        checks++;
        if (n_ovr != ov + 1) begin
            failures++;
            $display("FAIL two_ovr got=%0d exp=1", n_ovr - ov);
        end
        pop();
`endif
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL two_empty got=%b exp=0", valid);
        end
    endtask

    task automatic test_parity();
        int pe, fe;
        pe = n_perr;
        fe = n_ferr;
        send_frame(8'h1C, 1'b1, 1'b1);
        checks++;
        if (n_perr != pe + 1 || n_ferr != fe) begin
            failures++;
            $display("FAIL parity_pulse got=%0d/%0d exp=1/0",
                     n_perr - pe, n_ferr - fe);
        end
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL parity_valid got=%b exp=0", valid);
        end
    endtask

    task automatic test_stop();
        int pe, fe;
        pe = n_perr;
        fe = n_ferr;
        send_frame(8'h1C, 1'b1, 1'b0);
        checks++;
        if (n_ferr != fe + 1 || n_perr != pe) begin
            failures++;
            $display("FAIL stop_pulse got=%0d/%0d exp=1/0",
                     n_ferr - fe, n_perr - pe);
        end
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL stop_valid got=%b exp=0", valid);
        end
    endtask

    task automatic test_timeout();
        int fe;
        logic [7:0] b;
        fe = n_ferr;
        b = 8'h29;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        ps2_dat = 1'b1;
        #(60 * 40);
        checks++;
        if (n_ferr != fe + 1) begin
            failures++;
            $display("FAIL timeout_pulse got=%0d exp=1", n_ferr - fe);
        end
        send_frame(8'h29, 1'b0, 1'b1);
        checks++;
        if (valid !== 1'b1 || data !== 8'h29 || n_ferr != fe + 1) begin
            failures++;
            $display("FAIL timeout_next got=%b/%h/%0d exp=1/29/1",
                     valid, data, n_ferr - fe);
        end
        pop();
    endtask

    task automatic test_glitch();
        int pe, fe;
        logic [7:0] b;
        pe = n_perr;
        fe = n_ferr;
        b = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(b[i]);
        #(HALF);
        ps2_clk = 1'b0;
        #40;
        ps2_clk = 1'b1;
        #(HALF);
        for (int i = 3; i < 8; i++) send_bit(b[i]);
        send_bit(~^b);
        send_bit(1'b1);
        #(HALF * 2);
        checks++;
        if (valid !== 1'b1 || data !== 8'h5A) begin
            failures++;
            $display("FAIL glitch_data got=%b/%h exp=1/5a", valid, data);
        end
        checks++;
        if (n_perr != pe || n_ferr != fe) begin
            failures++;
            $display("FAIL glitch_errs got=%0d/%0d exp=0/0",
                     n_perr - pe, n_ferr - fe);
        end
        pop();
    endtask

    task automatic test_overrun();
        int ov;
        ov = n_ovr;
`ifdef PS2_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1);
        checks++;
        if (n_ovr != ov + 1) begin
            failures++;
            $display("FAIL ovr_pulse got=%0d exp=1", n_ovr - ov);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (valid !== 1'b1 || data !== 8'(i)) begin
                failures++;
                $display("FAIL ovr_read%0d got=%b/%h exp=1/%h",
                         i, valid, data, 8'(i));
            end
            pop();
        end
`else
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        checks++;
        if (n_ovr != ov + 1) begin
            failures++;
            $display("FAIL ovr_pulse got=%0d exp=1", n_ovr - ov);
        end
        checks++;
        if (valid !== 1'b1 || data !== 8'h11) begin
            failures++;
            $display("FAIL ovr_keep got=%b/%h exp=1/11", valid, data);
        end
        pop();
`endif
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL ovr_empty got=%b exp=0", valid);
        end
    endtask

    task automatic test_reset_mid();
        int pe, fe, ov;
        logic [7:0] b;
        send_frame(8'h55, 1'b0, 1'b1);
        b = 8'h33;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(b[i]);
        pe = n_perr;
        fe = n_ferr;
        ov = n_ovr;
        @(negedge clk);
        rst = 1'b0;
        ps2_dat = 1'b1;
        #100;
        @(negedge clk);
        rst = 1'b1;
        #(60 * 40);
        checks++;
        if (valid !== 1'b0 || data !== 8'h00) begin
            failures++;
            $display("FAIL rstmid_buf got=%b/%h exp=0/00", valid, data);
        end
        checks++;
        if (n_perr != pe || n_ferr != fe || n_ovr != ov) begin
            failures++;
            $display("FAIL rstmid_pulses got=%0d/%0d/%0d exp=0/0/0",
                     n_perr - pe, n_ferr - fe, n_ovr - ov);
        end
        send_frame(8'h1C, 1'b0, 1'b1);
        checks++;
        if (valid !== 1'b1 || data !== 8'h1C) begin
            failures++;
            $display("FAIL rstmid_next got=%b/%h exp=1/1c", valid, data);
        end
        pop();
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_frames();
        test_parity();
        test_stop();
        test_timeout();
        test_glitch();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
